// File: rtl/print_uart_tx.sv
// print_uart_tx
//   Serial console sink for the core's print port. Each PRINT_EN pulse
//   pushes one 32-bit word into a small FIFO. Words are printed as eight
//   uppercase hex ASCII characters plus a line feed, sent as UART 8N1.
//
// Ports
//   CLK         clock, rising edge
//   RESET       synchronous, active-high reset
//   PRINT_VAL   word to print, qualified by PRINT_EN
//   PRINT_EN    one-cycle push strobe (every high cycle is a word)
//   TX          registered UART line, idle high
//   BUSY        FIFO non-empty or transmitter not idle
//   OVERFLOW    sticky dropped-push flag, cleared only by RESET
//   FIFO_COUNT  words held in the FIFO (not counting the one in flight)
module print_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [31:0]                 PRINT_VAL,
    input  logic                        PRINT_EN,
    output logic                        TX,
    output logic                        BUSY,
    output logic                        OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // FIFO storage and bookkeeping
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          fifo_ne, push, pop;

    // transmitter
    state_t        state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_cnt, bit_cnt_n, bit_nxt;
    logic [3:0]    char_idx, char_idx_n;
    logic [31:0]   word, word_n;
    logic          tx, tx_n;
    logic          bit_end;
    logic [7:0]    ch;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        hex_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign fifo_ne = (count != '0);
    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign push    = PRINT_EN && ((count != FULL_CNT) || pop);
    assign bit_end = (baud == BAUD_LAST);
    assign bit_nxt = bit_cnt + 3'd1;
    // The word is shifted left one nibble per character, so the current
    // digit always sits in [31:28]; index 8 is the trailing LF.
    assign ch      = (char_idx == 4'd8) ? 8'h0A : hex_ascii(word[31:28]);

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= PRINT_VAL;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (PRINT_EN && !push)
                OVERFLOW <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            baud     <= '0;
            bit_cnt  <= '0;
            char_idx <= '0;
            word     <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud     <= baud_n;
            bit_cnt  <= bit_cnt_n;
            char_idx <= char_idx_n;
            word     <= word_n;
            tx       <= tx_n;
        end
    end

    // tx_n is the line level for the bit that begins on the coming edge.
    always_comb begin
        state_n    = state;
        baud_n     = baud + 1'b1;
        bit_cnt_n  = bit_cnt;
        char_idx_n = char_idx;
        word_n     = word;
        tx_n       = tx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                baud_n = '0;
                tx_n   = 1'b1;
                if (fifo_ne) begin
                    pop        = 1'b1;
                    word_n     = mem[rd_ptr];
                    char_idx_n = '0;
                    state_n    = START;
                    tx_n       = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_n    = '0;
                    bit_cnt_n = '0;
                    state_n   = DATA;
                    tx_n      = ch[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_cnt_n = bit_nxt;
                        tx_n      = ch[bit_nxt];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (char_idx != 4'd8) begin
                        char_idx_n = char_idx + 4'd1;
                        word_n     = {word[27:0], 4'h0};
                        state_n    = START;
                        tx_n       = 1'b0;
                    end else if (fifo_ne) begin
                        // chain straight into the next word, no idle gap
                        pop        = 1'b1;
                        word_n     = mem[rd_ptr];
                        char_idx_n = '0;
                        state_n    = START;
                        tx_n       = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                baud_n  = '0;
                tx_n    = 1'b1;
            end
        endcase
    end

    assign TX         = tx;
    assign BUSY       = fifo_ne || (state != IDLE);
    assign FIFO_COUNT = count;

endmodule

// File: tb/tb_print_uart_tx.sv
// tb_print_uart_tx
//   Directed bench for print_uart_tx with CLKS_PER_BIT = 4, FIFO_DEPTH = 4.
//   A line monitor decodes TX frames (every cycle of every bit is checked
//   for stability) into a byte queue with the cycle each start bit began.
module tb_print_uart_tx;

    logic        clk;
    logic        rst;
    logic [31:0] val;
    logic        en;
    logic        tx;
    logic        busy;
    logic        ovf;
    logic [2:0]  fcnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [7:0] byte_q [$];
    int         start_q [$];
    int         mon_err  = 0;
    logic       mon_hold = 1'b1;
    int         mon_pos;
    logic [7:0] mon_sh;

    print_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .CLK        (clk),
        .RESET      (rst),
        .PRINT_VAL  (val),
        .PRINT_EN   (en),
        .TX         (tx),
        .BUSY       (busy),
        .OVERFLOW   (ovf),
        .FIFO_COUNT (fcnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // UART frame decoder: 40 samples per character at the negative edge.
    initial begin
        mon_pos = -1;
        mon_sh  = '0;
        forever begin
            @(negedge clk);
            if (mon_hold) begin
                mon_pos = -1;
            end else begin
                if (mon_pos < 0 && tx === 1'b0) begin
                    mon_pos = 0;
                    start_q.push_back(cyc);
                end
                if (mon_pos >= 0) begin
                    if (mon_pos < 4) begin
                        if (tx !== 1'b0) mon_err++;
                    end else if (mon_pos < 36) begin
                        if (mon_pos % 4 == 0) mon_sh[3'((mon_pos - 4) / 4)] = tx;
                        else if (tx !== mon_sh[3'((mon_pos - 4) / 4)]) mon_err++;
                    end else begin
                        if (tx !== 1'b1) mon_err++;
                    end
                    mon_pos++;
                    if (mon_pos == 40) begin
                        byte_q.push_back(mon_sh);
                        mon_pos = -1;
                    end
                end
            end
        end
    end

    task automatic clear_mon();
        byte_q.delete();
        start_q.delete();
        mon_err = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_hold = 1'b1;
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_mon();
        mon_hold = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; val = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx !== 1'b1)   begin n_bad++; $display("FAIL reset_tx got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (ovf !== 1'b0)  begin n_bad++; $display("FAIL reset_ovf got %b want 0", ovf); end
        n_cmp++; if (fcnt !== 3'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", fcnt); end
        rst = 1'b0;
        @(negedge clk);
        clear_mon();
        mon_hold = 1'b0;
    endtask

    task automatic test_single();
        string s = "000000A5\n";
        int t0, gaps;
        clear_mon();
        @(negedge clk); en = 1'b1; val = 32'h0000_00A5;
        @(negedge clk); en = 1'b0; t0 = cyc;
        n_cmp++; if (fcnt !== 3'd1) begin n_bad++; $display("FAIL single_cnt_push got %0d want 1", fcnt); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_rise got %b want 1", busy); end
        n_cmp++; if (tx !== 1'b1)   begin n_bad++; $display("FAIL single_tx_before_pop got %b want 1", tx); end
        @(negedge clk);
        n_cmp++; if (tx !== 1'b0)   begin n_bad++; $display("FAIL single_tx_start got %b want 0", tx); end
        n_cmp++; if (fcnt !== 3'd0) begin n_bad++; $display("FAIL single_cnt_pop got %0d want 0", fcnt); end
        for (int i = 0; i < 500 && busy === 1'b1; i++) @(negedge clk);
        n_cmp++; if (cyc - t0 != 361) begin n_bad++; $display("FAIL single_busy_fall got %0d want 361", cyc - t0); end
        repeat (2) @(negedge clk);
        n_cmp++; if (byte_q.size() != s.len()) begin n_bad++; $display("FAIL single_len got %0d want %0d", byte_q.size(), s.len()); end
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            n_cmp++; if (got !== s[i]) begin n_bad++; $display("FAIL single_byte%0d got %h want %h", i, got, s[i]); end
        end
        n_cmp++; if (start_q.size() == 0 || start_q[0] != t0 + 1) begin n_bad++; $display("FAIL single_latency got %0d want %0d", (start_q.size() > 0) ? start_q[0] : -1, t0 + 1); end
        gaps = 0;
        for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i-1] != 40) gaps++;
        n_cmp++; if (gaps != 0)   begin n_bad++; $display("FAIL single_char_spacing got %0d bad want 0", gaps); end
        n_cmp++; if (mon_err != 0) begin n_bad++; $display("FAIL single_framing got %0d errors want 0", mon_err); end
    endtask

    task automatic test_hex();
        string s = "89ABCDEF\n01234567\n";
        int gaps;
        clear_mon();
        @(negedge clk); en = 1'b1; val = 32'h89AB_CDEF;
        @(negedge clk); val = 32'h0123_4567;
        n_cmp++; if (fcnt !== 3'd1) begin n_bad++; $display("FAIL hex_cnt0 got %0d want 1", fcnt); end
        @(negedge clk); en = 1'b0;
        n_cmp++; if (fcnt !== 3'd1) begin n_bad++; $display("FAIL hex_cnt1 got %0d want 1", fcnt); end
        for (int i = 0; i < 1000 && busy === 1'b1; i++) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hex_timeout got busy=%b want 0", busy); end
        n_cmp++; if (fcnt !== 3'd0) begin n_bad++; $display("FAIL hex_cnt_end got %0d want 0", fcnt); end
        repeat (2) @(negedge clk);
        n_cmp++; if (byte_q.size() != s.len()) begin n_bad++; $display("FAIL hex_len got %0d want %0d", byte_q.size(), s.len()); end
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            n_cmp++; if (got !== s[i]) begin n_bad++; $display("FAIL hex_byte%0d got %h want %h", i, got, s[i]); end
        end
        gaps = 0;
        for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i-1] != 40) gaps++;
        n_cmp++; if (gaps != 0)    begin n_bad++; $display("FAIL hex_back_to_back got %0d gaps want 0", gaps); end
        n_cmp++; if (mon_err != 0) begin n_bad++; $display("FAIL hex_framing got %0d errors want 0", mon_err); end
    endtask

    task automatic test_overflow();
        string s = {"00000001\n", "00000002\n", "00000003\n", "00000004\n", "00000005\n"};
        logic [2:0] exp_cnt [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        clear_mon();
        @(negedge clk); en = 1'b1; val = 32'd1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++; if (fcnt !== exp_cnt[i]) begin n_bad++; $display("FAIL ovf_cnt%0d got %0d want %0d", i, fcnt, exp_cnt[i]); end
            if (i == 4) begin
                n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_early got %b want 0", ovf); end
            end
            if (i == 5) begin
                n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", ovf); end
                en = 1'b0;
            end else begin
                val = 32'(i + 2);
            end
        end
        for (int i = 0; i < 2500 && busy === 1'b1; i++) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovf_timeout got busy=%b want 0", busy); end
        n_cmp++; if (ovf !== 1'b1)  begin n_bad++; $display("FAIL ovf_sticky got %b want 1", ovf); end
        repeat (2) @(negedge clk);
        n_cmp++; if (byte_q.size() != s.len()) begin n_bad++; $display("FAIL ovf_len got %0d want %0d", byte_q.size(), s.len()); end
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            n_cmp++; if (got !== s[i]) begin n_bad++; $display("FAIL ovf_byte%0d got %h want %h", i, got, s[i]); end
        end
    endtask

    task automatic test_full_pop();
        string s = {"11111111\n", "22222222\n", "33333333\n", "44444444\n", "55555555\n", "FFFF0000\n"};
        int p;
        do_reset();
        @(negedge clk); en = 1'b1; val = 32'h1111_1111;
        @(negedge clk); en = 1'b0;
        @(negedge clk); p = cyc;
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL full_first_start got %b want 0", tx); end
        en = 1'b1; val = 32'h2222_2222;
        @(negedge clk); val = 32'h3333_3333;
        @(negedge clk); val = 32'h4444_4444;
        @(negedge clk); val = 32'h5555_5555;
        @(negedge clk); en = 1'b0;
        n_cmp++; if (fcnt !== 3'd4) begin n_bad++; $display("FAIL full_fill got %0d want 4", fcnt); end
        while (cyc < p + 359) @(negedge clk);
        en = 1'b1; val = 32'hFFFF_0000;
        @(negedge clk); en = 1'b0;
        n_cmp++; if (fcnt !== 3'd4) begin n_bad++; $display("FAIL full_pop_cnt got %0d want 4", fcnt); end
        n_cmp++; if (ovf !== 1'b0)  begin n_bad++; $display("FAIL full_pop_ovf got %b want 0", ovf); end
        n_cmp++; if (tx !== 1'b0)   begin n_bad++; $display("FAIL full_pop_next_start got %b want 0", tx); end
        for (int i = 0; i < 3000 && busy === 1'b1; i++) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_timeout got busy=%b want 0", busy); end
        repeat (2) @(negedge clk);
        n_cmp++; if (byte_q.size() != s.len()) begin n_bad++; $display("FAIL full_len got %0d want %0d", byte_q.size(), s.len()); end
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            n_cmp++; if (got !== s[i]) begin n_bad++; $display("FAIL full_byte%0d got %h want %h", i, got, s[i]); end
        end
        n_cmp++; if (mon_err != 0) begin n_bad++; $display("FAIL full_framing got %0d errors want 0", mon_err); end
    endtask

    task automatic test_reset_mid();
        string s = "CAFEF00D\n";
        int p;
        do_reset();
        @(negedge clk); en = 1'b1; val = 32'h1234_5678;
        @(negedge clk); val = 32'hDEAD_0001;
        @(negedge clk); val = 32'hDEAD_0002; p = cyc;
        @(negedge clk); en = 1'b0;
        n_cmp++; if (fcnt !== 3'd2) begin n_bad++; $display("FAIL rmid_queued got %0d want 2", fcnt); end
        // character 2 is '3' (0x33); its data bit 3 spans cycles p+96..p+99
        while (cyc < p + 97) @(negedge clk);
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL rmid_bit3 got %b want 0", tx); end
        mon_hold = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (tx !== 1'b1)   begin n_bad++; $display("FAIL rmid_tx got %b want 1", tx); end
        n_cmp++; if (fcnt !== 3'd0) begin n_bad++; $display("FAIL rmid_cnt got %0d want 0", fcnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_cmp++; if (ovf !== 1'b0)  begin n_bad++; $display("FAIL rmid_ovf got %b want 0", ovf); end
        repeat (3) @(negedge clk);
        clear_mon();
        mon_hold = 1'b0;
        @(negedge clk); en = 1'b1; val = 32'hCAFE_F00D;
        @(negedge clk); en = 1'b0;
        for (int i = 0; i < 600 && busy === 1'b1; i++) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_timeout got busy=%b want 0", busy); end
        repeat (2) @(negedge clk);
        n_cmp++; if (byte_q.size() != s.len()) begin n_bad++; $display("FAIL rmid_len got %0d want %0d", byte_q.size(), s.len()); end
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            n_cmp++; if (got !== s[i]) begin n_bad++; $display("FAIL rmid_byte%0d got %h want %h", i, got, s[i]); end
        end
        n_cmp++; if (mon_err != 0) begin n_bad++; $display("FAIL rmid_framing got %0d errors want 0", mon_err); end
    endtask

    task automatic test_idle();
        int bad_tx = 0;
        int bad_busy = 0;
        clear_mon();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1)   bad_tx++;
            if (busy !== 1'b0) bad_busy++;
        end
        n_cmp++; if (bad_tx != 0)   begin n_bad++; $display("FAIL idle_tx got %0d low cycles want 0", bad_tx); end
        n_cmp++; if (bad_busy != 0) begin n_bad++; $display("FAIL idle_busy got %0d busy cycles want 0", bad_busy); end
        n_cmp++; if (byte_q.size() != 0) begin n_bad++; $display("FAIL idle_bytes got %0d want 0", byte_q.size()); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; val = '0;
        test_reset();
        test_single();
        test_hex();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/print_uart_tx.md
# print_uart_tx

Serial console sink for the core's print port. Each `PRINT_EN` pulse delivers one 32-bit `PRINT_VAL` word. The block buffers the word in a small FIFO, formats it as 8 uppercase hex ASCII characters followed by a line feed, and shifts the characters out as UART 8N1 on `TX`. It sits at top level beside the core and is the only path from program print stores to the board's USB-UART bridge.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, default 4: word entries; must be a power of 2, ≥ 2.
- `CLK`  in  1  clock; all logic on the rising edge.
- `RESET`  in  1  reset; synchronous, active-high.
- `PRINT_VAL`  in  32  word to print; valid when `PRINT_EN` = 1.
- `PRINT_EN`  in  1  one-cycle push strobe; every high cycle is a separate word.
- `TX`  out  1  UART serial line; idle high.
- `BUSY`  out  1  high while the FIFO is non-empty or the transmitter is not IDLE.
- `OVERFLOW`  out  1  sticky; set when a push is dropped, cleared only by `RESET`.
- `FIFO_COUNT`  out  $clog2(FIFO_DEPTH)+1  number of words held; excludes the word in flight.

## Operation
- **Reset:** on an edge with `RESET` = 1: `TX` = 1, `BUSY` = 0, `OVERFLOW` = 0, `FIFO_COUNT` = 0, FIFO pointers = 0, FSM = IDLE, character index = 0, baud counter = 0. Any in-flight word is abandoned with no partial stop bit; `TX` is high from that edge.
- **Push:** `PRINT_EN` = 1 at an edge writes `PRINT_VAL` to the FIFO if either condition holds:
  - `FIFO_COUNT` < `FIFO_DEPTH`, or
  - a pop occurs at the same edge.
  Otherwise the word is dropped and `OVERFLOW` is set.
- **Pop:** occurs when the FSM is IDLE and the FIFO is non-empty, or at the final cycle of the LF stop bit when the FIFO is non-empty. The popped word is loaded into the 32-bit shift word, and the character index is set to 0.
- **Simultaneous push and pop:** `FIFO_COUNT` is unchanged, and both pointers advance. Pointers wrap modulo `FIFO_DEPTH`.
- **Character sequence:** index 0–7 are the nibbles [31:28] down to [3:0]. The ASCII encoding is:
  - nibble 0–9 → 0x30–0x39;
  - nibble A–F → 0x41–0x46;
  - index 8 → 0x0A (LF).
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START on pop; `TX` = 0.
  - START → DATA after `CLKS_PER_BIT` cycles; bit counter = 0.
  - DATA: `TX` = character bit[bit counter], LSB first. Each bit is held for `CLKS_PER_BIT` cycles. After bit 7 → STOP.
  - STOP: `TX` = 1 for `CLKS_PER_BIT` cycles. At the end:
    - if index < 8: index+1, → START;
    - else if FIFO non-empty: pop, → START;
    - else → IDLE.
- **Baud counter:** counts 0..`CLKS_PER_BIT`−1 and resets to 0 at every bit boundary and on every state change.

## Timing
- `TX` is a registered output; no combinational path from any input to `TX`.
- **Latency:** `PRINT_EN` sampled at edge k with the block idle and the FIFO empty:
  - word written at edge k, `FIFO_COUNT` = 1 after edge k;
  - pop at edge k+1, `TX` falls after edge k+1, `FIFO_COUNT` = 0.
- **Frame length:** one character = 10 × `CLKS_PER_BIT` cycles. One word = 90 × `CLKS_PER_BIT` cycles.
- **Back-to-back:** there is zero idle gap between characters, and between words when the FIFO is non-empty.
- **`BUSY` timing:** `BUSY` rises after the push edge. It falls after the edge that ends the last stop bit with the FIFO empty.
- `FIFO_COUNT` and `OVERFLOW` update on the same edge as the push or pop that changes them.

## Test plan
- **Single word:** `CLKS_PER_BIT` = 4; push 0x000000A5 at edge 0 → `TX` falls after edge 1. Byte stream decodes to 0x30 ×6, 0x41, 0x35, 0x0A. Each bit lasts exactly 4 cycles. `BUSY` falls 361 edges after the push.
- **Hex coverage:** push 0x89ABCDEF, then 0x01234567 on consecutive cycles → decoded "89ABCDEF\n01234567\n" with no idle cycle between words. `FIFO_COUNT` sequence 1, 1, 0.
- **Overflow:** `FIFO_DEPTH` = 4; pulse `PRINT_EN` on 6 consecutive edges with values 1–6.
  - `FIFO_COUNT` goes 1, 1, 2, 3, 4, 4.
  - `OVERFLOW` = 1 after the 6th edge.
  - Output is words 1–5 only.
- **Full plus pop:** fill the FIFO to 4 during transmission, then assert `PRINT_EN` on exactly the LF-stop end edge.
  - Push is accepted, `FIFO_COUNT` stays 4, `OVERFLOW` stays 0.
  - The new word prints last.
- **Reset mid-operation:** assert `RESET` during the DATA bit 3 of character 2 with 2 words queued.
  - After the edge: `TX` = 1, `FIFO_COUNT` = 0, `BUSY` = 0, `OVERFLOW` = 0.
  - A fresh push afterwards prints correctly.
- **Idle line:** 1000 cycles with no `PRINT_EN` → `TX` constantly 1, `BUSY` = 0.
